mul_rr_sched: RTL and testbench

Round-robin scheduler that shares one sequential `MUL` multiplier (start/finish handshake, `2*WIDTH`-bit product) among `NREQ` requesters. It arbitrates pending requests, latches the winner's operands, issues a single `start` pulse, and waits for `finish` under a watchdog. It then returns the product to the winning requester. It sits between the requesting units and the `MUL` instance in the top level; it does not instantiate `MUL` itself.

---
 rtl/mul_rr_sched_pkg.sv | 16 +
 rtl/mul_rr_sched_rr_pick.sv | 26 ++
 rtl/mul_rr_sched.sv | 133 +++++++++++++
 tb/tb_mul_rr_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_rr_sched_pkg.sv
// mul_sched_pkg: shared FSM encoding, default sizing and index-width helper
// for the round-robin multiplier scheduler.
package mul_sched_pkg;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 32;

    // Bits needed to hold an index in 0..n-1, never less than one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_rr_sched_rr_pick.sv
// rr_pick: combinational round-robin picker; the search starts one past last_grant.
module rr_pick
    import mul_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int IW  = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic            valid,
    output logic [IW-1:0]   winner
);

    // Walk from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        valid  = 1'b0;
        winner = last_grant;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[(int'(last_grant) + i) % NREQ]) begin
                valid  = 1'b1;
                winner = IW'((int'(last_grant) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/mul_rr_sched.sv
// mul_rr_sched: shares one sequential multiplier among NREQ requesters with
// round-robin arbitration, a start/finish handshake and a WAIT watchdog.
module mul_rr_sched
    import mul_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         done,
    output logic [2*WIDTH-1:0]      res_out,
    output logic                    err,
    output logic                    busy,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_res,
    input  logic                    mul_finish
);

    localparam int IW = idx_w(NREQ);
    localparam int TW = idx_w(TIMEOUT);

    state_t             state_q, state_d;
    logic [IW-1:0]      grant_q, grant_d, last_q, last_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [NREQ-1:0]    ack_q, ack_d, done_q, done_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               err_q, err_d, busy_q, busy_d, start_q, start_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               pick_valid;
    logic [IW-1:0]      pick_id;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req),
        .last_grant (last_q),
        .valid      (pick_valid),
        .winner     (pick_id)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        tmr_d   = tmr_q;
        a_d     = a_q;
        b_d     = b_q;
        ack_d   = '0;
        done_d  = '0;
        res_d   = '0;
        err_d   = 1'b0;
        start_d = 1'b0;
        case (state_q)
            IDLE: if (pick_valid) begin
                state_d          = START;
                grant_d          = pick_id;
                a_d              = a_in[pick_id*WIDTH +: WIDTH];
                b_d              = b_in[pick_id*WIDTH +: WIDTH];
                ack_d[pick_id]   = 1'b1;
                start_d          = 1'b1;
            end
            START: begin
                tmr_d   = '0;
                state_d = WAIT;
            end
            // A finish arriving on the last watchdog cycle still counts as success.
            WAIT: begin
                tmr_d = tmr_q + 1'b1;
                if (mul_finish) begin
                    res_d            = mul_res;
                    done_d[grant_q]  = 1'b1;
                    state_d          = DONE;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    err_d            = 1'b1;
                    done_d[grant_q]  = 1'b1;
                    state_d          = DONE;
                end
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NREQ - 1);
            tmr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tmr_q   <= tmr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            res_q   <= res_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            start_q <= start_d;
        end
    end

    assign ack       = ack_q;
    assign done      = done_q;
    assign res_out   = res_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign mul_start = start_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;

endmodule

// File: tb/tb_mul_rr_sched.sv
// tb_mul_rr_sched: directed table-driven bench with a stub multiplier that
// finishes eight cycles after start (or never, when disabled).
module tb_mul_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] a_in, b_in;
    logic [3:0]  ack, done;
    logic [15:0] res_out;
    logic        err, busy, mul_start;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] mul_res;
    logic        mul_finish;

    logic        stub_en   = 1'b1;
    logic        stray_fin = 1'b0;
    logic        fin       = 1'b0;
    logic [3:0]  cnt       = '0;
    logic [15:0] stub_res  = '0;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    mul_rr_sched #(.WIDTH(8), .NREQ(4), .TIMEOUT(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .ack        (ack),
        .done       (done),
        .res_out    (res_out),
        .err        (err),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_res    (mul_res),
        .mul_finish (mul_finish)
    );

    // Stub multiplier: finish asserted in the 8th cycle after the start cycle.
    always @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            fin <= 1'b0;
        end else begin
            fin <= 1'b0;
            if (mul_start && stub_en) cnt <= 4'd7;
            else if (cnt != 0) begin
                cnt <= cnt - 1'b1;
                if (cnt == 1) begin
                    fin      <= 1'b1;
                    stub_res <= 16'(mul_a) * 16'(mul_b);
                end
            end
        end
    end

    assign mul_finish = fin | stray_fin;
    assign mul_res    = stub_res;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] a;
        logic [31:0] b;
        logic        stub;
        logic        stray;
        int          id;
        logic [15:0] res;
        logic        err;
        int          cyc;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic fail_bound(input string nm);
        n_tot++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " ack"}, 32'(ack), 0);
        chk({nm, " done"}, 32'(done), 0);
        chk({nm, " res_out"}, 32'(res_out), 0);
        chk({nm, " err"}, 32'(err), 0);
        chk({nm, " busy"}, 32'(busy), 0);
        chk({nm, " mul_start"}, 32'(mul_start), 0);
        chk({nm, " mul_a"}, 32'(mul_a), 0);
        chk({nm, " mul_b"}, 32'(mul_b), 0);
    endtask

    task automatic do_op(input string nm, input logic [3:0] r, input logic [31:0] a,
                         input logic [31:0] b, input int id, input logic [15:0] eres,
                         input logic eerr, input int ecyc, input logic stray);
        int k;
        @(negedge clk);
        req  = r;
        a_in = a;
        b_in = b;
        k = 0;
        do begin @(negedge clk); k++; end while (ack == 0 && k < 10);
        if (ack == 0) begin fail_bound({nm, " ack"}); req = '0; return; end
        chk({nm, " ack"}, 32'(ack), 32'd1 << id);
        chk({nm, " mul_start"}, 32'(mul_start), 1);
        chk({nm, " mul_a"}, 32'(mul_a), 32'(a[id*8 +: 8]));
        chk({nm, " mul_b"}, 32'(mul_b), 32'(b[id*8 +: 8]));
        chk({nm, " busy"}, 32'(busy), 1);
        req       = '0;
        stray_fin = stray;
        k = 0;
        do begin @(negedge clk); stray_fin = 1'b0; k++; end while (done == 0 && k < 64);
        if (done == 0) begin fail_bound({nm, " done"}); return; end
        chk({nm, " done"}, 32'(done), 32'd1 << id);
        chk({nm, " res_out"}, 32'(res_out), 32'(eres));
        chk({nm, " err"}, 32'(err), 32'(eerr));
        chk({nm, " latency"}, k, ecyc);
        @(negedge clk);
        chk({nm, " idle busy"}, 32'(busy), 0);
        chk({nm, " idle done"}, 32'(done), 0);
        chk({nm, " idle res"}, 32'(res_out), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, seen;
        int exp_seq[9] = '{0, 2, 0, 2, 0, 2, 0, 1, 2};
        int prods[4]   = '{10, 40, 90, 160};

        tbl[0] = '{4'b1111, 32'h10_00_02_FF, 32'h10_09_07_FF, 1'b1, 1'b0, 0, 16'd65025, 1'b0, 9};
        tbl[1] = '{4'b1110, 32'h10_00_02_FF, 32'h10_09_07_FF, 1'b1, 1'b0, 1, 16'd14,    1'b0, 9};
        tbl[2] = '{4'b1100, 32'h10_00_02_FF, 32'h10_09_07_FF, 1'b1, 1'b0, 2, 16'd0,     1'b0, 9};
        tbl[3] = '{4'b1000, 32'h10_00_02_FF, 32'h10_09_07_FF, 1'b1, 1'b0, 3, 16'd256,   1'b0, 9};
        tbl[4] = '{4'b0001, 32'h00_00_00_03, 32'h00_00_00_05, 1'b1, 1'b0, 0, 16'd15,    1'b0, 9};
        tbl[5] = '{4'b0010, 32'h00_00_06_00, 32'h00_00_07_00, 1'b0, 1'b0, 1, 16'd0,     1'b1, 33};
        tbl[6] = '{4'b0010, 32'h00_00_06_00, 32'h00_00_07_00, 1'b1, 1'b0, 1, 16'd42,    1'b0, 9};
        tbl[7] = '{4'b1000, 32'h0C_00_00_00, 32'h0B_00_00_00, 1'b1, 1'b1, 3, 16'd132,   1'b0, 9};

        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        foreach (tbl[i]) begin
            stub_en = tbl[i].stub;
            do_op($sformatf("vec%0d", i), tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].id,
                  tbl[i].res, tbl[i].err, tbl[i].cyc, tbl[i].stray);
        end
        stub_en = 1'b1;

        // Stray finish while idle must not wake the scheduler.
        @(negedge clk);
        stray_fin = 1'b1;
        @(negedge clk);
        stray_fin = 1'b0;
        chk("stray idle busy", 32'(busy), 0);
        chk("stray idle done", 32'(done), 0);
        @(negedge clk);
        chk("stray idle busy2", 32'(busy), 0);
        chk("stray idle done2", 32'(done), 0);

        // Fairness with held requests; req[1] joins at the sixth grant.
        a_in = 32'h28_1E_14_0A;
        b_in = 32'h04_03_02_01;
        req  = 4'b0101;
        for (int j = 0; j < 9; j++) begin
            k = 0;
            do begin @(negedge clk); k++; end while (ack == 0 && k < 10);
            if (ack == 0) begin fail_bound("fair ack"); break; end
            chk($sformatf("fair%0d ack", j), 32'(ack), 32'd1 << exp_seq[j]);
            if (j > 0) chk($sformatf("fair%0d gap", j), k, 2);
            if (j == 5) req[1] = 1'b1;
            if (j == 7) req[1] = 1'b0;
            k = 0;
            do begin @(negedge clk); k++; end while (done == 0 && k < 20);
            if (done == 0) begin fail_bound("fair done"); break; end
            chk($sformatf("fair%0d done", j), 32'(done), 32'd1 << exp_seq[j]);
            chk($sformatf("fair%0d res", j), 32'(res_out), prods[exp_seq[j]]);
        end
        req = '0;

        // Reset three cycles into WAIT aborts the operation silently.
        @(negedge clk);
        @(negedge clk);
        req  = 4'b0001;
        a_in = 32'h00_00_00_09;
        b_in = 32'h00_00_00_09;
        k = 0;
        do begin @(negedge clk); k++; end while (ack == 0 && k < 10);
        if (ack == 0) fail_bound("rst_wait ack");
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("rst_wait");
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done != 0 || busy) seen++;
        end
        chk("rst_wait no done", seen, 0);
        do_op("post_rst", 4'b0100, 32'h00_05_00_00, 32'h00_06_00_00, 2, 16'd30, 1'b0, 9, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
